// File: rtl/wb_pkg.sv
// Shared defaults and helpers for the multi-lane writeback unit.
// Register-address width is derived here so every file sizes fields the same way.
package wb_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_NREG   = 8;
  localparam int DEF_LANES  = 2;
  localparam int DEF_RPORTS = 4;
  localparam int DEF_CNT_W  = 2;

  typedef enum logic [0:0] {
    SRC_ALU  = 1'b0,
    SRC_LOAD = 1'b1
  } wb_src_e;

  // Minimum of one bit so single-entry selects still produce a legal vector.
  function automatic int ra_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/writeback_unit_mp_if.sv
// Writeback, issue and register-read bundle of the writeback unit.
// The master side drives requests and addresses; the slave side returns data and status.
interface writeback_unit_mp_if #(
  parameter int DATA_W = wb_pkg::DEF_DATA_W,
  parameter int NREG   = wb_pkg::DEF_NREG,
  parameter int LANES  = wb_pkg::DEF_LANES,
  parameter int RPORTS = wb_pkg::DEF_RPORTS
);
  localparam int RA_W = wb_pkg::ra_width(NREG);

  logic [LANES-1:0]         wb_valid;
  logic [LANES-1:0]         wb_isld;
  logic [LANES*RA_W-1:0]    wb_rd;
  logic [LANES*DATA_W-1:0]  wb_ldresult;
  logic [LANES*DATA_W-1:0]  wb_aluresult;
  logic [LANES*DATA_W-1:0]  wb_result;
  logic [LANES-1:0]         iss_valid;
  logic [LANES*RA_W-1:0]    iss_rd;
  logic                     iss_ready;
  logic [RPORTS*RA_W-1:0]   rd_addr;
  logic [RPORTS*DATA_W-1:0] rd_data;
  logic [RPORTS-1:0]        rd_busy;

  modport master (
    output wb_valid, wb_isld, wb_rd, wb_ldresult, wb_aluresult,
    output iss_valid, iss_rd, rd_addr,
    input  wb_result, iss_ready, rd_data, rd_busy
  );

  modport slave (
    input  wb_valid, wb_isld, wb_rd, wb_ldresult, wb_aluresult,
    input  iss_valid, iss_rd, rd_addr,
    output wb_result, iss_ready, rd_data, rd_busy
  );

endinterface

// File: rtl/wb_pend_counter.sv
// Pending-write counter for one architectural register.
// Issues add, writebacks subtract; the result floors at zero instead of wrapping.
module wb_pend_counter #(
  parameter int CNT_W = 2,
  parameter int CW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] i_inc,
  input  logic [CW-1:0] i_dec,
  input  logic          i_accept,
  output logic          o_ovf,
  output logic          o_busy
);
  localparam int SW = ((CNT_W > CW) ? CNT_W : CW) + 1;
  localparam logic [SW-1:0] MAXV = SW'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] r_pend;
  logic [SW-1:0]    w_sum;
  logic [SW-1:0]    w_after_wb;
  logic [SW-1:0]    w_after_all;
  logic [CNT_W-1:0] w_next;

  // Issues are summed before subtracting so a same-cycle issue/writeback nets out.
  always_comb begin
    w_after_wb  = (SW'(r_pend) > SW'(i_dec)) ? (SW'(r_pend) - SW'(i_dec)) : '0;
    w_sum       = SW'(r_pend) + SW'(i_inc);
    w_after_all = (w_sum > SW'(i_dec)) ? (w_sum - SW'(i_dec)) : '0;
    o_ovf       = (w_after_all > MAXV);
    o_busy      = (w_after_wb != '0);
    w_next      = i_accept ? w_after_all[CNT_W-1:0] : w_after_wb[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_next;
    end
  end

endmodule

// File: rtl/writeback_unit_mp.sv
// Multi-lane writeback unit: result select, register file with same-cycle read
// bypass, and a per-register pending-write scoreboard that gates issue groups.
module writeback_unit_mp
  import wb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NREG    = DEF_NREG,
  parameter int LANES   = DEF_LANES,
  parameter int RPORTS  = DEF_RPORTS,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int R0_ZERO = 1
) (
  input logic clk,
  input logic rst,
  writeback_unit_mp_if.slave bus
);
  localparam int RA_W = ra_width(NREG);
  localparam int CW   = ra_width(LANES + 1);

  logic [DATA_W-1:0] w_res     [LANES];
  logic [DATA_W-1:0] w_regs    [NREG];
  logic [DATA_W-1:0] w_wr_data [NREG];
  logic [NREG-1:0]   w_wr_en;
  logic [NREG-1:0]   w_ovf;
  logic [NREG-1:0]   w_busy;
  logic              w_accept;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_res[gi] = (wb_src_e'(bus.wb_isld[gi]) == SRC_LOAD)
                       ? bus.wb_ldresult[gi*DATA_W +: DATA_W]
                       : bus.wb_aluresult[gi*DATA_W +: DATA_W];
      assign bus.wb_result[gi*DATA_W +: DATA_W] = w_res[gi];
    end

    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      localparam bit HARD_ZERO = (R0_ZERO != 0) && (gi == 0);
      logic [CW-1:0]     w_iss_cnt;
      logic [CW-1:0]     w_wb_cnt;
      logic              w_hit;
      logic [DATA_W-1:0] w_data;
      logic [DATA_W-1:0] r_data;

      // Lanes scanned in ascending order so the highest matching lane supplies the data.
      always_comb begin
        w_iss_cnt = '0;
        w_wb_cnt  = '0;
        w_hit     = 1'b0;
        w_data    = '0;
        if (!HARD_ZERO) begin
          for (int l = 0; l < LANES; l++) begin
            if (bus.iss_valid[l] && (bus.iss_rd[l*RA_W +: RA_W] == RA_W'(gi))) begin
              w_iss_cnt = w_iss_cnt + CW'(1);
            end
            if (bus.wb_valid[l] && (bus.wb_rd[l*RA_W +: RA_W] == RA_W'(gi))) begin
              w_wb_cnt = w_wb_cnt + CW'(1);
              w_hit    = 1'b1;
              w_data   = w_res[l];
            end
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_data <= '0;
        end else if (w_hit) begin
          r_data <= w_data;
        end
      end

      assign w_regs[gi]    = r_data;
      assign w_wr_en[gi]   = w_hit;
      assign w_wr_data[gi] = w_data;

      wb_pend_counter #(
        .CNT_W (CNT_W),
        .CW    (CW)
      ) u_pend (
        .clk      (clk),
        .rst      (rst),
        .i_inc    (w_iss_cnt),
        .i_dec    (w_wb_cnt),
        .i_accept (w_accept),
        .o_ovf    (w_ovf[gi]),
        .o_busy   (w_busy[gi])
      );
    end

    // Read ports see this cycle's writeback data before it lands in the array.
    for (genvar gi = 0; gi < RPORTS; gi++) begin : g_rport
      logic [RA_W-1:0] w_addr;
      assign w_addr = bus.rd_addr[gi*RA_W +: RA_W];
      assign bus.rd_data[gi*DATA_W +: DATA_W] =
        rst ? '0 : (w_wr_en[w_addr] ? w_wr_data[w_addr] : w_regs[w_addr]);
      assign bus.rd_busy[gi] = !rst && w_busy[w_addr];
    end
  endgenerate

  assign w_accept      = !rst && (w_ovf == '0);
  assign bus.iss_ready = w_accept;

endmodule

// File: tb/tb_writeback_unit_mp.sv
// Self-checking bench for writeback_unit_mp: directed steps plus random traffic
// compared every cycle against an arithmetic model of registers and pending counts.
module tb_writeback_unit_mp;
  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int LANES  = 2;
  localparam int RPORTS = 4;
  localparam int CNT_W  = 2;
  localparam int RA_W   = 3;
  localparam int PMAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  writeback_unit_mp_if #(
    .DATA_W(DATA_W), .NREG(NREG), .LANES(LANES), .RPORTS(RPORTS)
  ) bus ();

  writeback_unit_mp #(
    .DATA_W(DATA_W), .NREG(NREG), .LANES(LANES), .RPORTS(RPORTS),
    .CNT_W(CNT_W), .R0_ZERO(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int m_reg  [NREG];
  int m_pend [NREG];
  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lane_res(input int l);
    return bus.wb_isld[l] ? int'(bus.wb_ldresult[l*DATA_W +: DATA_W])
                          : int'(bus.wb_aluresult[l*DATA_W +: DATA_W]);
  endfunction

  function automatic int wb_hits(input int r);
    int n = 0;
    for (int l = 0; l < LANES; l++)
      if (bus.wb_valid[l] && int'(bus.wb_rd[l*RA_W +: RA_W]) == r) n++;
    return n;
  endfunction

  function automatic int iss_hits(input int r);
    int n = 0;
    for (int l = 0; l < LANES; l++)
      if (bus.iss_valid[l] && int'(bus.iss_rd[l*RA_W +: RA_W]) == r) n++;
    return n;
  endfunction

  function automatic bit model_ready();
    if (rst) return 1'b0;
    for (int r = 1; r < NREG; r++)
      if (m_pend[r] + iss_hits(r) - wb_hits(r) > PMAX) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [DATA_W-1:0] rdata(input int p);
    return bus.rd_data[p*DATA_W +: DATA_W];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_reg[r]  = 0;
      m_pend[r] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int l = 0; l < LANES; l++)
      chk($sformatf("%s wb_result[%0d]", tag, l), bus.wb_result[l*DATA_W +: DATA_W], lane_res(l));
    chk({tag, " iss_ready"}, bus.iss_ready, model_ready());
    for (int p = 0; p < RPORTS; p++) begin
      int a = int'(bus.rd_addr[p*RA_W +: RA_W]);
      int v = 0;
      int b = 0;
      if (!rst && a != 0) begin
        v = m_reg[a];
        for (int l = 0; l < LANES; l++)
          if (bus.wb_valid[l] && int'(bus.wb_rd[l*RA_W +: RA_W]) == a) v = lane_res(l);
        b = (m_pend[a] - wb_hits(a) > 0) ? 1 : 0;
      end
      chk($sformatf("%s rd_data[%0d]", tag, p), rdata(p), v);
      chk($sformatf("%s rd_busy[%0d]", tag, p), bus.rd_busy[p], b);
    end
  endtask

  task automatic update_model();
    bit ok;
    int n;
    if (rst) begin
      model_reset();
      return;
    end
    ok = model_ready();
    for (int r = 1; r < NREG; r++) begin
      n = m_pend[r] + (ok ? iss_hits(r) : 0) - wb_hits(r);
      m_pend[r] = (n < 0) ? 0 : n;
    end
    for (int l = 0; l < LANES; l++) begin
      int d = int'(bus.wb_rd[l*RA_W +: RA_W]);
      if (bus.wb_valid[l] && d != 0) m_reg[d] = lane_res(l);
    end
  endtask

  task automatic cycle(input string tag);
    @(negedge clk);
    check_all(tag);
    $display("cyc %0d %s ready=%0b busy=%b", cyc, tag, bus.iss_ready, bus.rd_busy);
    @(posedge clk);
    update_model();
    cyc++;
    #1;
  endtask

  task automatic idle();
    bus.wb_valid = '0; bus.wb_isld = '0; bus.wb_rd = '0;
    bus.wb_ldresult = '0; bus.wb_aluresult = '0;
    bus.iss_valid = '0; bus.iss_rd = '0; bus.rd_addr = '0;
  endtask

  task automatic set_wb(input int l, input bit v, input bit ld, input int rd,
                        input logic [DATA_W-1:0] ldd, input logic [DATA_W-1:0] alu);
    bus.wb_valid[l] = v;
    bus.wb_isld[l]  = ld;
    bus.wb_rd[l*RA_W +: RA_W] = RA_W'(rd);
    bus.wb_ldresult[l*DATA_W +: DATA_W]  = ldd;
    bus.wb_aluresult[l*DATA_W +: DATA_W] = alu;
  endtask

  task automatic set_iss(input int l, input bit v, input int rd);
    bus.iss_valid[l] = v;
    bus.iss_rd[l*RA_W +: RA_W] = RA_W'(rd);
  endtask

  task automatic set_addr(input int p, input int a);
    bus.rd_addr[p*RA_W +: RA_W] = RA_W'(a);
  endtask

  task automatic rand_inputs();
    for (int l = 0; l < LANES; l++) begin
      set_wb(l, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, NREG-1),
             DATA_W'($urandom), DATA_W'($urandom));
      set_iss(l, 1'($urandom_range(0, 1)), $urandom_range(0, NREG-1));
    end
    for (int p = 0; p < RPORTS; p++) set_addr(p, $urandom_range(0, NREG-1));
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    rand_inputs();
    #2;
    check_all("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle();

    // single ALU write, then every register read back
    set_wb(0, 1, 0, 1, 16'h0000, 16'hABCD);
    cycle("wr_r1");
    idle();
    for (int p = 0; p < RPORTS; p++) set_addr(p, p);
    #1;
    for (int p = 0; p < RPORTS; p++) chk($sformatf("r%0d", p), rdata(p), (p == 1) ? 16'hABCD : 16'h0000);
    for (int p = 0; p < RPORTS; p++) set_addr(p, p + 4);
    #1;
    for (int p = 0; p < RPORTS; p++) chk($sformatf("r%0d", p + 4), rdata(p), 16'h0000);
    cycle("rd_all");

    // two lanes to the same register: lane1 load wins, visible through bypass
    idle();
    set_wb(0, 1, 0, 2, 16'h0000, 16'h1111);
    set_wb(1, 1, 1, 2, 16'h1234, 16'h9999);
    set_addr(0, 2);
    #1;
    chk("bypass_r2", rdata(0), 16'h1234);
    cycle("wr_r2");
    idle();
    set_addr(0, 2);
    #1;
    chk("stored_r2", rdata(0), 16'h1234);
    cycle("rd_r2");

    // invalid lane ignored; register 0 hard-wired
    idle();
    set_wb(0, 0, 0, 3, 16'h0000, 16'h5678);
    cycle("nowr_r3");
    idle();
    set_addr(0, 3);
    set_wb(0, 1, 0, 0, 16'h0000, 16'hFFFF);
    set_addr(1, 0);
    #1;
    chk("r3_zero", rdata(0), 16'h0000);
    chk("r0_bypass", rdata(1), 16'h0000);
    cycle("wr_r0");
    idle();
    set_addr(1, 0);
    #1;
    chk("r0_stored", rdata(1), 16'h0000);
    cycle("rd_r0");

    // fill register 5 pending count to its limit
    for (int k = 0; k < 3; k++) begin
      idle();
      set_iss(0, 1, 5);
      set_addr(0, 5);
      #1;
      chk($sformatf("iss5_ready_%0d", k), bus.iss_ready, 1'b1);
      cycle("iss5");
      idle();
      set_addr(0, 5);
      #1;
      chk($sformatf("iss5_busy_%0d", k), bus.rd_busy[0], 1'b1);
    end
    idle();
    set_iss(0, 1, 5);
    set_addr(0, 5);
    #1;
    chk("iss5_full", bus.iss_ready, 1'b0);
    cycle("iss5_stall");
    idle();
    set_iss(0, 1, 5);
    set_wb(1, 1, 0, 5, 16'h0000, 16'h0055);
    set_addr(0, 5);
    #1;
    chk("iss5_wb_ready", bus.iss_ready, 1'b1);
    cycle("iss5_wb");
    for (int k = 0; k < 3; k++) begin
      idle();
      set_wb(0, 1, 0, 5, 16'h0000, 16'h0500);
      set_addr(0, 5);
      #1;
      chk($sformatf("drain5_busy_%0d", k), bus.rd_busy[0], (k < 2) ? 1'b1 : 1'b0);
      cycle("drain5");
    end

    // same-cycle issue and writeback on register 4 nets out
    idle();
    set_iss(0, 1, 4);
    cycle("iss4");
    idle();
    set_iss(0, 1, 4);
    set_wb(0, 1, 0, 4, 16'h0000, 16'h0044);
    set_addr(0, 4);
    cycle("iss_wb4");
    idle();
    set_addr(0, 4);
    #1;
    chk("r4_busy_kept", bus.rd_busy[0], 1'b1);
    chk("r4_data", rdata(0), 16'h0044);
    cycle("hold4");
    idle();
    set_wb(0, 1, 0, 4, 16'h0000, 16'h0444);
    set_addr(0, 4);
    #1;
    chk("r4_busy_clear", bus.rd_busy[0], 1'b0);
    cycle("wb4");

    repeat (300) begin
      rand_inputs();
      cycle("rand");
    end

    // asynchronous reset with outstanding writes
    idle();
    set_iss(0, 1, 6);
    set_iss(1, 1, 6);
    set_addr(0, 6);
    #1;
    if (bus.iss_ready) begin
      cycle("iss6");
      idle();
      set_addr(0, 6);
      #1;
      chk("r6_busy_pre", bus.rd_busy[0], 1'b1);
    end else begin
      cycle("iss6_stall");
      idle();
      #1;
    end
    rst = 1'b1;
    model_reset();
    rand_inputs();
    for (int p = 0; p < RPORTS; p++) set_addr(p, p);
    #1;
    chk("arst_ready", bus.iss_ready, 1'b0);
    for (int p = 0; p < RPORTS; p++) begin
      chk($sformatf("arst_d%0d", p), rdata(p), 16'h0000);
      chk($sformatf("arst_b%0d", p), bus.rd_busy[p], 1'b0);
    end
    for (int p = 0; p < RPORTS; p++) set_addr(p, p + 4);
    #1;
    for (int p = 0; p < RPORTS; p++) begin
      chk($sformatf("arst_d%0d", p + 4), rdata(p), 16'h0000);
      chk($sformatf("arst_b%0d", p + 4), bus.rd_busy[p], 1'b0);
    end
    cycle("in_reset");
    rst = 1'b0;
    idle();
    set_addr(0, 6);
    #1;
    chk("cold_busy6", bus.rd_busy[0], 1'b0);
    cycle("cold");

    repeat (60) begin
      rand_inputs();
      cycle("rand2");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/writeback_unit_mp.md
WRITEBACK_UNIT_MP -- requirements
Module: writeback_unit_mp

Interface
REQ-001 Parameter DATA_W, 16, register data width.
REQ-002 Parameter NREG, 8, architectural register count (power of two, >=2); RA_W = log2(NREG).
REQ-003 Parameter LANES, 2, writeback lanes and issue lanes.
REQ-004 Parameter RPORTS, 4, read ports.
REQ-005 Parameter CNT_W, 2, width of per-register pending-write counter.
REQ-006 Parameter R0_ZERO, 1, when 1 register 0 reads as zero and ignores writes.
REQ-007 One clock; reset asynchronous, active-high: ports clk and rst.
REQ-008 clk  in  1  clock; all state updates on rising edge.
REQ-009 rst  in  1  asynchronous active-high reset.
REQ-010 wb_valid  in  LANES  per-lane writeback request.
REQ-011 wb_isld  in  LANES  per-lane select: 1 = load result, 0 = ALU result.
REQ-012 wb_rd  in  LANES*RA_W  per-lane destination register.
REQ-013 wb_ldresult  in  LANES*DATA_W  per-lane load data.
REQ-014 wb_aluresult  in  LANES*DATA_W  per-lane ALU data.
REQ-015 wb_result  out  LANES*DATA_W  per-lane selected data, combinational.
REQ-016 iss_valid  in  LANES  per-lane issue of an instruction writing iss_rd.
REQ-017 iss_rd  in  LANES*RA_W  per-lane issue destination.
REQ-018 iss_ready  out  1  issue group accepted this cycle.
REQ-019 rd_addr  in  RPORTS*RA_W  read addresses.
REQ-020 rd_data  out  RPORTS*DATA_W  read data, combinational.
REQ-021 rd_busy  out  RPORTS  register has a pending write (after this cycle's updates considered, see REQ-029).

Function
REQ-022 wb_result[i] SHALL equal wb_ldresult[i] when wb_isld[i], else wb_aluresult[i], independent of wb_valid.
REQ-023 On each rising edge, for each lane with wb_valid set, reg_file[wb_rd] SHALL be written with wb_result of that lane; one-cycle write latency.
REQ-024 Two or more valid lanes to the same register in one cycle: highest lane index SHALL win (program order).
REQ-025 R0_ZERO=1: writes to register 0 SHALL be dropped; reads of register 0 SHALL return 0; its pending counter SHALL stay 0 and never block issue.
REQ-026 rd_data SHALL bypass: if a valid lane writes rd_addr this cycle, return that lane's wb_result (highest lane wins), else stored value.
REQ-027 Per register, pend[r] (CNT_W bits) SHALL add the number of accepted issues to r and subtract the number of valid writebacks to r each cycle.
REQ-028 iss_ready SHALL be 0 when any valid issue lane would push pend[r] above 2^CNT_W-1 after same-cycle writebacks; then no lane of the group is accepted (all-or-nothing).
REQ-029 rd_busy[p] SHALL be 1 when pend[rd_addr] minus this-cycle valid writebacks to that register is nonzero.
REQ-030 Writeback to a register with pend=0 (underflow) SHALL write data and leave pend at 0.
REQ-031 Issue and writeback to same register, same cycle: net change applied; counter neither wraps nor saturates silently.

Reset
REQ-032 rst SHALL clear every reg_file entry to 0 and every pend to 0, immediately and asynchronously.
REQ-033 During rst, iss_ready SHALL be 0, rd_busy all 0, rd_data all 0; wb_valid/iss_valid ignored.
REQ-034 Reset mid-operation SHALL discard all pending counts; first edge after release behaves as cold start.

Structure
REQ-035 Shared package wb_pkg SHALL hold default DATA_W, NREG, LANES and the RA_W computation function.
REQ-036 Sub-module wb_pend_counter SHALL implement one register's pending counter (inc count, dec count, overflow flag); instantiated NREG times.

Verification
REQ-037 Reset, then lane0 wb_valid, isld=0, rd=1, alu=ABCD -> next cycle reg1 reads ABCD, others 0000.
REQ-038 lane0 rd=2 alu=1111, lane1 rd=2 isld=1 ld=1234, same cycle -> reg2 = 1234; same-cycle rd_data[addr=2] = 1234.
REQ-039 wb_valid=0 with rd=3, alu=5678 -> reg3 stays 0000; R0_ZERO=1 write 0xFFFF to reg0 -> reads 0000.
REQ-040 Issue rd=5 three times (CNT_W=2) -> rd_busy for 5 stays 1, fourth issue with no writeback -> iss_ready=0 and pend unchanged; one writeback -> iss_ready=1.
REQ-041 Issue rd=4 and writeback rd=4 in same cycle with pend=1 -> pend stays 1, rd_busy=1; next writeback -> busy 0.
REQ-042 Assert rst mid-sequence with pend nonzero -> all registers 0000, all rd_busy 0 without waiting for clk.
